// File: rtl/hdmi_pkg.sv
// Shared HDMI/VGA types and 640x480 raster timing constants.
// HDMI_PS_UFLOW_FILL_EN selects a visible blue underflow fill pixel instead of black.
package hdmi_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } rgb_t;

    typedef enum logic [1:0] {WAIT_SOF, WAIT_FRAME, RUN} ps_state_e;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

`ifdef HDMI_PS_UFLOW_FILL_EN
    localparam rgb_t UFLOW_FILL = 24'h0000FF;
`else
    localparam rgb_t UFLOW_FILL = 24'h000000;
`endif

endpackage

// File: rtl/hdmi_pixel_streamer_if.sv
// SOF/EOL framed ready/valid pixel stream.
interface hdmi_pixel_streamer_if #(parameter int COLOR_DEPTH = 24);
    logic                   valid;
    logic                   ready;
    logic [COLOR_DEPTH-1:0] data;
    logic                   sof;
    logic                   eol;

    modport master (output valid, data, sof, eol, input ready);
    modport slave  (input valid, data, sof, eol, output ready);
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with flush; pointers carry a wrap bit to tell full from empty.
module pixel_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/hdmi_pixel_streamer.sv
// Aligns a framed pixel stream to the controller's raster and feeds the TMDS encoders.
// HDMI_PS_UFLOW_FILL_EN (via hdmi_pkg) makes starved pixels blue instead of black.
module hdmi_pixel_streamer
    import hdmi_pkg::*;
#(
    parameter int COLOR_DEPTH = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int HA          = H_ACTIVE,
    parameter int VA          = V_ACTIVE
) (
    input  logic                        clk,
    input  logic                        rstn,
    hdmi_pixel_streamer_if.slave        s,
    input  logic                        i_frame_start,
    input  logic                        i_data_en,
    output logic [7:0]                  o_red,
    output logic [7:0]                  o_grn,
    output logic [7:0]                  o_blu,
    output logic                        o_locked,
    output logic                        o_underflow,
    output logic                        o_sync_lost
);
    localparam int EW = COLOR_DEPTH + 2;
    localparam int XW = $clog2(HA);
    localparam int YW = $clog2(VA);

    ps_state_e       state, state_nxt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [EW-1:0]   head;
    logic            full, empty, push, pop, flush;
    logic            run_de, at_origin, at_eol, frame_err;
    rgb_t            pix_q;

    assign at_origin = (x == '0) && (y == '0);
    assign at_eol    = (x == XW'(HA - 1));
    assign run_de    = (state == RUN) && i_data_en;
    assign pop       = run_de && !empty;
    // head = {sof, eol, pixel}; framing must match the raster position it lands on
    assign frame_err = pop && ((head[EW-1] != at_origin) || (head[EW-2] != at_eol));
    assign s.ready   = (state == WAIT_SOF) || !full;
    // pre-SOF beats are accepted and dropped; a flush drops any beat landing with it
    assign push      = s.valid && s.ready && !flush && ((state != WAIT_SOF) || s.sof);

    pixel_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data ({s.sof, s.eol, s.data}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= WAIT_SOF;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        case (state)
            WAIT_SOF:   if (s.valid && s.sof) state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (i_frame_start)    state_nxt = RUN;
            RUN: begin
                if (frame_err || (i_frame_start && !at_origin)) begin
                    flush     = 1'b1;
                    state_nxt = WAIT_SOF;
                end
            end
            default:    state_nxt = WAIT_SOF;
        endcase
    end

    // raster position only runs in RUN, so entering RUN always starts at (0,0)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x <= '0;
            y <= '0;
        end else if (state != RUN) begin
            x <= '0;
            y <= '0;
        end else if (i_data_en) begin
            if (at_eol) begin
                x <= '0;
                y <= (y == YW'(VA - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_q       <= '0;
            o_underflow <= 1'b0;
            o_sync_lost <= 1'b0;
        end else begin
            pix_q       <= !run_de ? rgb_t'('0) : (empty ? UFLOW_FILL : rgb_t'(head[COLOR_DEPTH-1:0]));
            o_underflow <= run_de && empty;
            o_sync_lost <= flush;
        end
    end

    assign o_red    = pix_q.red;
    assign o_grn    = pix_q.grn;
    assign o_blu    = pix_q.blu;
    assign o_locked = (state == RUN);
endmodule

// File: tb/tb_hdmi_pixel_streamer.sv
// Randomized scoreboard bench: a queue-level model predicts every output cycle.
module tb_hdmi_pixel_streamer;
    localparam int HA    = 8;
    localparam int VA    = 3;
    localparam int DEPTH = 16;
`ifdef HDMI_PS_UFLOW_FILL_EN
    localparam logic [23:0] FILL = 24'h0000FF;
`else
    localparam logic [23:0] FILL = 24'h000000;
`endif

    typedef struct {
        bit          sof;
        bit          eol;
        logic [23:0] pix;
    } beat_t;

    typedef struct {
        logic [23:0] pix;
        bit          uf;
        bit          sl;
        bit          lk;
        bit          real_pix;
    } exp_t;

    logic        clk = 0, rstn = 0, frame_start = 0, data_en = 0;
    logic [7:0]  o_red, o_grn, o_blu;
    logic        o_locked, o_underflow, o_sync_lost;

    hdmi_pixel_streamer_if #(.COLOR_DEPTH(24)) sif ();

    hdmi_pixel_streamer #(.COLOR_DEPTH(24), .FIFO_DEPTH(DEPTH), .HA(HA), .VA(VA)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s             (sif),
        .i_frame_start (frame_start),
        .i_data_en     (data_en),
        .o_red         (o_red),
        .o_grn         (o_grn),
        .o_blu         (o_blu),
        .o_locked      (o_locked),
        .o_underflow   (o_underflow),
        .o_sync_lost   (o_sync_lost)
    );

    always #5 clk = ~clk;

    int    total = 0, bad = 0;
    int    uf_cnt = 0, sl_cnt = 0;
    beat_t src_q[$];
    exp_t  exp_q[$];
    int    sent = 0, stall_at = -1, stall_len = 0, vld_pct = 100, gap_pct = 0;
    bit    src_hold = 0, cap_first = 0;
    logic [23:0] first_out = '0, sof_pix = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // source: presents queued beats, honours stalls and random valid gaps
    initial begin
        bit hs;
        sif.valid = 0; sif.data = '0; sif.sof = 0; sif.eol = 0;
        forever begin
            @(negedge clk);
            hs = sif.valid && sif.ready && rstn;
            @(posedge clk); #1;
            if (hs && src_q.size() > 0) begin
                src_q.delete(0);
                sent++;
            end
            if (stall_len > 0 && sent == stall_at) begin
                stall_len--;
                sif.valid = 0;
            end else if (src_hold || src_q.size() == 0 || $urandom_range(99) >= vld_pct) begin
                sif.valid = 0;
            end else begin
                sif.valid = 1;
                sif.sof   = src_q[0].sof;
                sif.eol   = src_q[0].eol;
                sif.data  = src_q[0].pix;
            end
        end
    end

    // reference model: mode 0 hunting SOF, 1 buffering, 2 streaming
    beat_t mq[$];
    int    mmode = 0, mx = 0, my = 0;
    always @(negedge clk) begin
        exp_t  e;
        beat_t b, hd;
        bit    rdy, fl;
        int    m0;
        if (!rstn) begin
            mq.delete();
            mmode = 0; mx = 0; my = 0;
        end else begin
            m0  = mmode;
            rdy = (m0 == 0) || (mq.size() < DEPTH);
            chk("s_ready", 32'(sif.ready), 32'(rdy));
            b  = '{sof: sif.sof, eol: sif.eol, pix: sif.data};
            e  = '{pix: 24'h0, uf: 0, sl: 0, lk: 0, real_pix: 0};
            fl = 0;
            if (m0 == 2) begin
                if (frame_start && (mx != 0 || my != 0)) fl = 1;
                if (data_en) begin
                    if (mq.size() == 0) begin
                        e.uf  = 1;
                        e.pix = FILL;
                    end else begin
                        hd = mq.pop_front();
                        e.pix = hd.pix;
                        e.real_pix = 1;
                        if (hd.sof != (mx == 0 && my == 0) || hd.eol != (mx == HA - 1)) fl = 1;
                    end
                    mx++;
                    if (mx == HA) begin
                        mx = 0;
                        my = (my + 1) % VA;
                    end
                end
                if (fl) begin
                    e.sl = 1;
                    mq.delete();
                    mmode = 0;
                end
            end else if (m0 == 1 && frame_start) begin
                mmode = 2; mx = 0; my = 0;
            end
            if (sif.valid && rdy && !fl) begin
                if (m0 != 0) mq.push_back(b);
                else if (b.sof) begin
                    mq.push_back(b);
                    mmode = 1;
                end
            end
            e.lk = (mmode == 2);
            exp_q.push_back(e);
        end
    end

    // monitor: one prediction per clock, compared just after the edge
    initial forever begin
        exp_t e;
        @(posedge clk); #2;
        if (!rstn) begin
            chk("rst_pix", 32'({o_red, o_grn, o_blu}), 32'h0);
            chk("rst_flags", 32'({o_locked, o_underflow, o_sync_lost}), 32'h0);
            chk("rst_ready", 32'(sif.ready), 32'h1);
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pixel", 32'({o_red, o_grn, o_blu}), 32'(e.pix));
            chk("underflow", 32'(o_underflow), 32'(e.uf));
            chk("sync_lost", 32'(o_sync_lost), 32'(e.sl));
            chk("locked", 32'(o_locked), 32'(e.lk));
            uf_cnt += int'(o_underflow);
            sl_cnt += int'(o_sync_lost);
            if (cap_first && e.real_pix) begin
                first_out = {o_red, o_grn, o_blu};
                cap_first = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_cyc(int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        src_hold = 1; data_en = 0; frame_start = 0;
        repeat (3) @(posedge clk);
        #3 rstn = 0;
        src_q.delete();
        stall_len = 0;
        repeat (3) @(posedge clk);
        #3 rstn = 1;
        sent = 0; src_hold = 0; uf_cnt = 0; sl_cnt = 0;
    endtask

    task automatic add_frame(int short_line);
        beat_t b;
        for (int l = 0; l < VA; l++) begin
            int len = (l == short_line) ? HA - 1 : HA;
            for (int p = 0; p < len; p++) begin
                b.sof = (l == 0 && p == 0);
                b.eol = (p == len - 1);
                b.pix = 24'($urandom);
                src_q.push_back(b);
            end
        end
    endtask

    task automatic add_junk(int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.sof = 0;
            b.eol = 1'($urandom);
            b.pix = 24'($urandom);
            src_q.push_back(b);
        end
    endtask

    task automatic de_run(int n);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                data_en = 0;
                step();
            end
            data_en = 1;
            step();
        end
        data_en = 0;
    endtask

    task automatic pulse_fs();
        frame_start = 1; step(); frame_start = 0; step();
    endtask

    task automatic raster(int frames);
        for (int f = 0; f < frames; f++) begin
            pulse_fs();
            step();
            for (int l = 0; l < VA; l++) begin
                de_run(HA);
                wait_cyc(3);
            end
        end
    endtask

    initial begin
        int idx;
        repeat (3) @(posedge clk);
        #3 rstn = 1;

        // aligned stream with junk ahead of SOF, source outruns raster
        add_junk(5);
        idx = src_q.size();
        add_frame(-1);
        add_frame(-1);
        sof_pix = src_q[idx].pix;
        wait_cyc(30);
        chk("full_backpressure", 32'(sif.ready), 32'h0);
        cap_first = 1;
        gap_pct = 20;
        raster(2);
        wait_cyc(2);
        chk("first_pix_is_sof", 32'(first_out), 32'(sof_pix));
        chk("s1_underflows", 32'(uf_cnt), 32'h0);
        chk("s1_sync_lost", 32'(sl_cnt), 32'h0);
        chk("s1_locked", 32'(o_locked), 32'h1);

        // source stall mid-line starves the raster
        do_reset();
        gap_pct = 0;
        add_frame(-1);
        stall_at = 12; stall_len = 20;
        wait_cyc(3);
        raster(2);
        wait_cyc(2);
        chk("s2_underflow_seen", 32'(uf_cnt > 0), 32'h1);
        chk("s2_sync_lost_seen", 32'(sl_cnt > 0), 32'h1);
        chk("s2_unlocked", 32'(o_locked), 32'h0);

        // short line: EOL one pixel early
        do_reset();
        add_frame(1);
        wait_cyc(30);
        raster(1);
        wait_cyc(2);
        chk("s3_sync_lost", 32'(sl_cnt), 32'h1);
        chk("s3_underflows", 32'(uf_cnt), 32'h0);
        chk("s3_unlocked", 32'(o_locked), 32'h0);
        chk("s3_ready", 32'(sif.ready), 32'h1);

        // early frame_start mid-line, then relock on the next SOF
        do_reset();
        add_frame(-1);
        add_frame(-1);
        wait_cyc(30);
        pulse_fs();
        de_run(5);
        step();
        pulse_fs();
        step();
        chk("s4_sync_lost", 32'(sl_cnt), 32'h1);
        chk("s4_unlocked", 32'(o_locked), 32'h0);
        wait_cyc(40);
        raster(1);
        wait_cyc(2);
        chk("s4_relocked", 32'(o_locked), 32'h1);
        chk("s4_no_new_loss", 32'(sl_cnt), 32'h1);
        chk("s4_underflows", 32'(uf_cnt), 32'h0);

        // random valid and data-enable gaps, then reset mid-frame
        do_reset();
        vld_pct = 60; gap_pct = 30;
        add_frame(-1);
        add_frame(-1);
        add_frame(-1);
        wait_cyc(10);
        raster(3);
        add_frame(-1);
        wait_cyc(20);
        pulse_fs();
        de_run(10);
        do_reset();
        vld_pct = 100; gap_pct = 10;
        add_frame(-1);
        wait_cyc(30);
        raster(1);
        wait_cyc(2);
        chk("s5_relock", 32'(o_locked), 32'h1);
        chk("s5_sync_lost", 32'(sl_cnt), 32'h0);
        chk("s5_underflows", 32'(uf_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
